// File: rtl/iec_multidrive_hub.sv
// iec_multidrive_hub: host IEC glitch filter, wired-AND bus resolution and shared phi2 enables for NUM_DRIVES drives
module iec_multidrive_hub #(
  parameter int NUM_DRIVES = 4,
  parameter int FILT_LEN = 2,
  parameter int CE_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic [NUM_DRIVES-1:0] pause,
  input  logic [NUM_DRIVES-1:0] drv_en,
  input  logic host_atn_in,
  input  logic host_clk_in,
  input  logic host_data_in,
  output logic host_clk_out,
  output logic host_data_out,
  input  logic [NUM_DRIVES-1:0] drv_clk_o,
  input  logic [NUM_DRIVES-1:0] drv_data_o,
  input  logic [NUM_DRIVES-1:0] drv_atna,
  output logic drv_atn_i,
  output logic drv_clk_i,
  output logic drv_data_i,
  output logic [NUM_DRIVES-1:0] ph2_r,
  output logic [NUM_DRIVES-1:0] ph2_f
);
  localparam int CW = $clog2(CE_DIV);
  localparam logic [CW-1:0] HALF = CW'(CE_DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(CE_DIV - 1);
  logic [2:0] raw, filt;
  logic [NUM_DRIVES-1:0] eff_data, eff_clk, ena;
  logic [CW-1:0] cnt;
  logic dand, cand;
  assign raw = {host_atn_in, host_clk_in, host_data_in};
  genvar l;
  for (l = 0; l < 3; l++) begin : g_filt
    logic [FILT_LEN-1:0] sr;
    logic [FILT_LEN:0] nxt;
    logic f;
    assign nxt = {sr, raw[l]};
    assign filt[l] = f;
    // output follows only once every stage agrees, so short pulses are swallowed
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        sr <= '1;
        f <= 1'b1;
      end else begin
        sr <= nxt[FILT_LEN-1:0];
        if (&sr || ~|sr) f <= sr[0];
      end
  end
  // a drive whose ATN-ack disagrees with the live ATN level holds DATA low
  assign eff_data = (drv_data_o & ~(drv_atna ^ {NUM_DRIVES{~filt[2]}})) | ~drv_en;
  assign eff_clk = drv_clk_o | ~drv_en;
  assign dand = &eff_data;
  assign cand = &eff_clk;
  assign drv_atn_i = filt[2];
  assign drv_clk_i = filt[1] & cand;
  assign drv_data_i = filt[0] & dand;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      ena <= '0;
      ph2_r <= '0;
      ph2_f <= '0;
      host_clk_out <= 1'b1;
      host_data_out <= 1'b1;
    end else begin
      host_clk_out <= cand;
      host_data_out <= dand;
      ph2_r <= (ce && cnt == '0) ? ena : '0;
      ph2_f <= (ce && cnt == HALF) ? ena : '0;
      if (ce) cnt <= cnt + 1'b1;
      // sampling just before the rising slot keeps every started cycle whole
      if (ce && cnt == LAST) ena <= ~pause & drv_en;
    end
endmodule

// File: tb/tb_iec_multidrive_hub.sv
// tb_iec_multidrive_hub: directed stimulus, per-cycle compare against a behavioural model plus literal spot checks
module tb_iec_multidrive_hub;
  localparam int N = 4, FL = 2, CD = 16;
  logic clk = 0, reset = 0, ce = 0;
  logic [N-1:0] pause = '0, drv_en = '0, drv_clk_o = '1, drv_data_o = '1, drv_atna = '0;
  logic host_atn_in = 1, host_clk_in = 1, host_data_in = 1;
  logic host_clk_out, host_data_out, drv_atn_i, drv_clk_i, drv_data_i;
  logic [N-1:0] ph2_r, ph2_f;
  int pass = 0, total = 0, cyc = 0;
  iec_multidrive_hub #(.NUM_DRIVES(N), .FILT_LEN(FL), .CE_DIV(CD)) dut (
    .clk(clk), .reset(reset), .ce(ce), .pause(pause), .drv_en(drv_en),
    .host_atn_in(host_atn_in), .host_clk_in(host_clk_in), .host_data_in(host_data_in),
    .host_clk_out(host_clk_out), .host_data_out(host_data_out),
    .drv_clk_o(drv_clk_o), .drv_data_o(drv_data_o), .drv_atna(drv_atna),
    .drv_atn_i(drv_atn_i), .drv_clk_i(drv_clk_i), .drv_data_i(drv_data_i),
    .ph2_r(ph2_r), .ph2_f(ph2_f));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // model: filtered lines as run lengths of equal samples, phase as tick count modulo CD
  bit mf[3], ml[3], smp[3];
  int mr[3], ticks;
  bit [N-1:0] mena, er, ef;
  bit hc, hd;
  bit [1:0] rr;
  function automatic bit [1:0] res();
    bit d = 1, c = 1;
    for (int i = 0; i < N; i++)
      if (drv_en[i]) begin
        if (!drv_data_o[i] || (drv_atna[i] != !mf[0])) d = 0;
        if (!drv_clk_o[i]) c = 0;
      end
    return {d, c};
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin mf[i] = 1; ml[i] = 1; mr[i] = FL; end
      ticks = 0; mena = 0; er = 0; ef = 0; hc = 1; hd = 1;
    end else begin
      {hd, hc} = res();
      smp = '{host_atn_in, host_clk_in, host_data_in};
      for (int i = 0; i < 3; i++) begin
        if (mr[i] >= FL) mf[i] = ml[i];
        if (smp[i] == ml[i]) begin if (mr[i] < FL) mr[i]++; end
        else begin ml[i] = smp[i]; mr[i] = 1; end
      end
      er = 0; ef = 0;
      if (ce) begin
        if (ticks % CD == 0) er = mena;
        if (ticks % CD == CD / 2) ef = mena;
        if (ticks % CD == CD - 1) mena = ~pause & drv_en;
        ticks++;
      end
    end
  end
  always @(negedge clk) begin
    rr = res();
    chk("bus", {drv_atn_i, drv_clk_i, drv_data_i}, {mf[0], mf[1] & rr[0], mf[2] & rr[1]});
    chk("host", {host_clk_out, host_data_out}, {hc, hd});
    chk("ph2_r", ph2_r, er);
    chk("ph2_f", ph2_f, ef);
  end
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic wait_r0(output int t);
    t = -1;
    for (int k = 0; k < 40 && t < 0; k++) begin
      @(posedge clk); #1;
      if (ph2_r[0]) t = cyc;
    end
    if (t < 0) chk("wait_ph2_r", 0, 1);
  endtask
  initial begin
    int n, lows, t0, tr, f1, r1, r0, ovl;
    int rt[$], ft[$];
    #1 reset = 1;
    ce = 1;
    @(negedge clk);
    chk("rst_ph2", {ph2_r, ph2_f}, 0);
    chk("rst_host", {host_clk_out, host_data_out}, 2'b11);
    chk("rst_atn", drv_atn_i, 1);
    tick(); tick();
    reset = 0;
    drv_en = 4'b0001;
    repeat (3) tick();
    host_atn_in = 0;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      @(posedge clk); #1;
      if (!drv_atn_i) n = k;
    end
    chk("atn_latency", n, 3);
    @(negedge clk);
    chk("ack_data", drv_data_i, 0);
    tick();
    @(negedge clk);
    chk("ack_host", host_data_out, 0);
    tick();
    drv_atna = 4'b0001;
    @(negedge clk);
    chk("ack_release", drv_data_i, 1);
    chk("ack_host_hold", host_data_out, 0);
    tick();
    @(negedge clk);
    chk("ack_host_rel", host_data_out, 1);
    tick();
    host_atn_in = 1; drv_atna = 0;
    repeat (5) tick();
    host_atn_in = 0;
    tick();
    host_atn_in = 1;
    lows = 0;
    repeat (6) begin @(posedge clk); #1; if (!drv_atn_i) lows++; end
    chk("glitch", lows, 0);
    tick();
    drv_en = '1; drv_clk_o = 4'b1011;
    repeat (2) tick();
    @(negedge clk);
    chk("wand_clk", drv_clk_i, 0);
    chk("wand_host", host_clk_out, 0);
    tick();
    drv_en = 4'b1011;
    @(negedge clk);
    chk("wand_dis", drv_clk_i, 1);
    chk("wand_host_hold", host_clk_out, 0);
    tick();
    @(negedge clk);
    chk("wand_host_rel", host_clk_out, 1);
    tick();
    drv_en = '1; drv_clk_o = '1; host_clk_in = 0;
    tick();
    host_clk_in = 1; host_data_in = 0;
    repeat (4) tick();
    host_data_in = 1;
    repeat (2 * CD) tick();
    wait_r0(t0);
    ovl = 0;
    repeat (32) begin
      @(posedge clk); #1;
      if (ph2_r[0]) rt.push_back(cyc - t0);
      if (ph2_f[0]) ft.push_back(cyc - t0);
      if (|(ph2_r & ph2_f)) ovl++;
    end
    chk("overlap", ovl, 0);
    chk("r_count", rt.size(), 2);
    chk("f_count", ft.size(), 2);
    if (rt.size() == 2 && ft.size() == 2) begin
      chk("r_period1", rt[0], 16);
      chk("r_period2", rt[1], 32);
      chk("f_after_r1", ft[0], 8);
      chk("f_after_r2", ft[1], 24);
    end
    repeat (40) begin tick(); ce = 1'($urandom_range(0, 1)); end
    ce = 1;
    repeat (2 * CD) tick();
    wait_r0(tr);
    tick();
    pause[1] = 1;
    f1 = 0; r1 = 0; r0 = 0;
    repeat (40) begin
      @(posedge clk); #1;
      f1 += int'(ph2_f[1]); r1 += int'(ph2_r[1]); r0 += int'(ph2_r[0]);
    end
    chk("pause_f1", f1, 1);
    chk("pause_r1", r1, 0);
    chk("pause_r0", r0, 2);
    pause[1] = 0;
    n = -1;
    for (int k = 0; k < 40 && n < 0; k++) begin
      @(posedge clk); #1;
      if (ph2_r[1]) begin n = cyc; chk("resume_aligned", ph2_r[0], 1); end
    end
    chk("resume_phase", (n < 0) ? 1 : (n - tr) % CD, 0);
    wait_r0(t0);
    tick(); tick(); tick();
    reset = 1;
    @(negedge clk);
    chk("mid_rst_ph2", {ph2_r, ph2_f}, 0);
    chk("mid_rst_host", {host_clk_out, host_data_out}, 2'b11);
    tick(); tick();
    reset = 0;
    n = 0;
    for (int k = 1; k <= 40 && n == 0; k++) begin
      @(posedge clk); #1;
      if (ph2_f[0]) chk("rst_no_f", 1, 0);
      if (ph2_r[0]) n = k;
    end
    chk("rst_first_r", n, 17);
    repeat (5) tick();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
